lut_loader: RTL and testbench

LUT_LOADER -- requirements
Module: lut_loader

---
 rtl/lut_loader_pkg.sv | 38 +++
 rtl/lut_loader_if.sv | 15 +
 rtl/lut_verify_cmp.sv | 58 +++++
 rtl/lut_loader.sv | 189 ++++++++++++++++++
 tb/tb_lut_loader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/lut_loader_pkg.sv
// Shared widths, LUT select encoding and FSM state type for the LUT loader.
package lut_pkg;

  localparam int ENTRY_W = 28;
  localparam int CHUNK_W = 7;
  localparam int IDX_W   = 13;
  localparam int ADDR_W  = 15;
  localparam int N_CHUNK = 4;
  localparam int N_LUT   = 4;

  typedef enum logic [1:0] {
    SEL_BPM1_I = 2'd0,
    SEL_BPM1_Q = 2'd1,
    SEL_BPM2_I = 2'd2,
    SEL_BPM2_Q = 2'd3
  } lut_sel_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } lut_state_e;

  // Picks 7-bit chunk k out of a 28-bit entry, low chunk at k=0.
  function automatic logic [CHUNK_W-1:0] get_chunk(input logic [ENTRY_W-1:0] d,
                                                   input logic [1:0] k);
    logic [CHUNK_W-1:0] c;
    case (k)
      2'd0:    c = d[6:0];
      2'd1:    c = d[13:7];
      2'd2:    c = d[20:14];
      default: c = d[27:21];
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lut_loader_if.sv
// Host-side entry handshake: one LUT entry offered per valid/ready transfer.
interface lut_wr_if;
  import lut_pkg::*;

  logic               wr_valid;
  logic               wr_ready;
  logic [ENTRY_W-1:0] wr_data;
  logic [IDX_W-1:0]   wr_idx;
  lut_sel_e           wr_sel;
  logic               verify_en;

  modport master (output wr_valid, wr_data, wr_idx, wr_sel, verify_en, input wr_ready);
  modport slave  (input wr_valid, wr_data, wr_idx, wr_sel, verify_en, output wr_ready);

endinterface

// File: rtl/lut_verify_cmp.sv
// Readback checker: delays the expected chunk and select by the LUT read
// latency, picks the addressed LUT's read data and flags any difference.
module lut_verify_cmp
  import lut_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_vld,
  input  logic [CHUNK_W-1:0] rd_exp,
  input  lut_sel_e           rd_sel,
  input  logic [CHUNK_W-1:0] lut_doutb0,
  input  logic [CHUNK_W-1:0] lut_doutb1,
  input  logic [CHUNK_W-1:0] lut_doutb2,
  input  logic [CHUNK_W-1:0] lut_doutb3,
  output logic               mismatch
);

  logic [RD_LATENCY-1:0] vld_q;
  logic [CHUNK_W-1:0]    exp_q [RD_LATENCY];
  lut_sel_e              sel_q [RD_LATENCY];
  logic [CHUNK_W-1:0]    rdata;

  // Delay line so the expected chunk lines up with the cycle its read data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        exp_q[i] <= '0;
        sel_q[i] <= SEL_BPM1_I;
      end
    end else begin
      vld_q[0] <= rd_vld;
      exp_q[0] <= rd_exp;
      sel_q[0] <= rd_sel;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
        sel_q[i] <= sel_q[i-1];
      end
    end
  end

  // Select the returning LUT's data and compare it against the delayed expectation.
  always_comb begin
    rdata = lut_doutb0;
    case (sel_q[RD_LATENCY-1])
      SEL_BPM1_I: rdata = lut_doutb0;
      SEL_BPM1_Q: rdata = lut_doutb1;
      SEL_BPM2_I: rdata = lut_doutb2;
      SEL_BPM2_Q: rdata = lut_doutb3;
      default:    rdata = lut_doutb0;
    endcase
    mismatch = vld_q[RD_LATENCY-1] && (rdata != exp_q[RD_LATENCY-1]);
  end

endmodule

// File: rtl/lut_loader.sv
// LUT loader: splits each 28-bit host entry into four 7-bit chunks written to
// one of four port-B LUTs, optionally reads them back and flags mismatches.
module lut_loader
  import lut_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  lut_wr_if.slave            bus,
  input  logic               err_clr,
  output logic [CHUNK_W-1:0] lut_dinb,
  output logic [ADDR_W-1:0]  lut_addrb,
  output logic [N_LUT-1:0]   lut_web,
  input  logic [CHUNK_W-1:0] lut_doutb0,
  input  logic [CHUNK_W-1:0] lut_doutb1,
  input  logic [CHUNK_W-1:0] lut_doutb2,
  input  logic [CHUNK_W-1:0] lut_doutb3,
  output logic               busy,
  output logic               verify_err,
  output logic [IDX_W-1:0]   err_idx,
  output logic [15:0]        wr_count
);

  localparam int DCW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  lut_state_e         state_q, state_d;
  logic [1:0]         k_q, k_d;
  logic [DCW-1:0]     dcnt_q, dcnt_d;
  logic [ENTRY_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  lut_sel_e           sel_q, sel_d;
  logic               ver_q, ver_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [N_LUT-1:0]   web_q, web_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CHUNK_W-1:0] din_q, din_d;
  logic               rdv_q, rdv_d;
  logic [CHUNK_W-1:0] rexp_q, rexp_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               verr_q, verr_d;
  logic [IDX_W-1:0]   eidx_q, eidx_d;
  logic               mismatch;

  lut_verify_cmp #(.RD_LATENCY(RD_LATENCY)) u_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_vld     (rdv_q),
    .rd_exp     (rexp_q),
    .rd_sel     (sel_q),
    .lut_doutb0 (lut_doutb0),
    .lut_doutb1 (lut_doutb1),
    .lut_doutb2 (lut_doutb2),
    .lut_doutb3 (lut_doutb3),
    .mismatch   (mismatch)
  );

  // Next state, then the port-B outputs for the cycle that next state describes,
  // so every output comes straight from a register.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    ver_d   = ver_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.wr_valid && ready_q) begin
          data_d  = bus.wr_data;
          idx_d   = bus.wr_idx;
          sel_d   = bus.wr_sel;
          ver_d   = bus.verify_en;
          k_d     = 2'd0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (k_q == 2'd3) begin
          cnt_d   = cnt_q + 16'd1;
          k_d     = 2'd0;
          state_d = ver_q ? S_READ : S_IDLE;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_READ: begin
        if (k_q == 2'd3) begin
          k_d     = 2'd0;
          dcnt_d  = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DCW'(RD_LATENCY - 1)) begin
          state_d = S_IDLE;
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    web_d  = '0;
    addr_d = '0;
    din_d  = '0;
    rdv_d  = 1'b0;
    rexp_d = '0;
    case (state_d)
      S_WRITE: begin
        web_d[sel_d] = 1'b1;
        addr_d       = {idx_d, k_d};
        din_d        = get_chunk(data_d, k_d);
      end
      S_READ: begin
        addr_d = {idx_d, k_d};
        rdv_d  = 1'b1;
        rexp_d = get_chunk(data_d, k_d);
      end
      default: ;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);

    verr_d = verr_q;
    eidx_d = eidx_q;
    if (err_clr) verr_d = 1'b0;
    if (mismatch) begin
      verr_d = 1'b1;
      eidx_d = idx_q;
    end
  end

  // All control state and registered outputs; reset abandons any entry in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      dcnt_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      sel_q   <= SEL_BPM1_I;
      ver_q   <= 1'b0;
      cnt_q   <= '0;
      web_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rdv_q   <= 1'b0;
      rexp_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      verr_q  <= 1'b0;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      ver_q   <= ver_d;
      cnt_q   <= cnt_d;
      web_q   <= web_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdv_q   <= rdv_d;
      rexp_q  <= rexp_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      verr_q  <= verr_d;
      eidx_q  <= eidx_d;
    end
  end

  assign bus.wr_ready = ready_q;
  assign lut_web      = web_q;
  assign lut_addrb    = addr_q;
  assign lut_dinb     = din_q;
  assign busy         = busy_q;
  assign verify_err   = verr_q;
  assign err_idx      = eidx_q;
  assign wr_count     = cnt_q;

endmodule

// File: tb/tb_lut_loader.sv
// Directed bench for lut_loader with a latency-1 RAM model behind port B.
module tb_lut_loader;
  import lut_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        err_clr;
  logic [6:0]  lut_dinb;
  logic [14:0] lut_addrb;
  logic [3:0]  lut_web;
  logic [6:0]  doutQ [4];
  logic        busy;
  logic        verify_err;
  logic [12:0] err_idx;
  logic [15:0] wr_count;

  logic [6:0]  ram [4][32768];
  logic        corruptEn;
  logic [14:0] corruptAddr;

  int testCount;
  int failCount;

  lut_wr_if bus ();

  lut_loader #(.RD_LATENCY(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .err_clr    (err_clr),
    .lut_dinb   (lut_dinb),
    .lut_addrb  (lut_addrb),
    .lut_web    (lut_web),
    .lut_doutb0 (doutQ[0]),
    .lut_doutb1 (doutQ[1]),
    .lut_doutb2 (doutQ[2]),
    .lut_doutb3 (doutQ[3]),
    .busy       (busy),
    .verify_err (verify_err),
    .err_idx    (err_idx),
    .wr_count   (wr_count)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Four port-B LUT models with one cycle of read latency and optional corruption.
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (lut_web[n]) ram[n][lut_addrb] <= lut_dinb;
      doutQ[n] <= (corruptEn && lut_addrb == corruptAddr) ? 7'h00 : ram[n][lut_addrb];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Offers one entry at a negedge, waits (bounded) for acceptance, returns in cycle 1.
  task automatic applyStimulus(input logic [27:0] d, input logic [12:0] idx,
                               input logic [1:0] sel, input logic ver);
    int waitCnt;
    waitCnt = 0;
    bus.wr_data   = d;
    bus.wr_idx    = idx;
    bus.wr_sel    = lut_sel_e'(sel);
    bus.verify_en = ver;
    bus.wr_valid  = 1'b1;
    while (!bus.wr_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("accept_ready", 32'(bus.wr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  // Checks the four write cycles starting in cycle 1, leaves the bench in cycle 5.
  task automatic checkWrites(input string tag, input logic [14:0] base, input logic [3:0] web,
                             input logic [6:0] c0, input logic [6:0] c1,
                             input logic [6:0] c2, input logic [6:0] c3);
    logic [6:0] c [4];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int k = 0; k < 4; k++) begin
      checkOutput({tag, "_addr"}, 32'(lut_addrb), 32'(base) + 32'(k));
      checkOutput({tag, "_din"},  32'(lut_dinb),  32'(c[k]));
      checkOutput({tag, "_web"},  32'(lut_web),   32'(web));
      @(negedge clk);
    end
  endtask

  initial begin
    int acc [3];
    int n;
    testCount = 0;
    failCount = 0;
    rst_n = 1'b0;
    err_clr = 1'b0;
    corruptEn = 1'b0;
    corruptAddr = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.wr_idx = '0;
    bus.wr_sel = SEL_BPM1_I;
    bus.verify_en = 1'b0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(bus.wr_ready), 32'd0);
    checkOutput("rst_busy",  32'(busy), 32'd0);
    checkOutput("rst_count", 32'(wr_count), 32'd0);
    checkOutput("rst_web",   32'(lut_web), 32'd0);
    rst_n = 1'b1;
    checkOutput("ready_before_edge", 32'(bus.wr_ready), 32'd0);
    @(negedge clk);
    checkOutput("ready_after_edge", 32'(bus.wr_ready), 32'd1);

    // Plain write, verify off.
    applyStimulus(28'h0ABCDEF, 13'd5, 2'd2, 1'b0);
    checkWrites("w1", 15'd20, 4'b0100, 7'h6F, 7'h1B, 7'h2F, 7'h05);
    checkOutput("w1_count", 32'(wr_count), 32'd1);
    checkOutput("w1_ready", 32'(bus.wr_ready), 32'd1);
    checkOutput("w1_web_idle", 32'(lut_web), 32'd0);

    // Same entry with readback, clean RAM.
    applyStimulus(28'h0ABCDEF, 13'd5, 2'd2, 1'b1);
    checkWrites("w2", 15'd20, 4'b0100, 7'h6F, 7'h1B, 7'h2F, 7'h05);
    for (int k = 0; k < 4; k++) begin
      checkOutput("rd_addr", 32'(lut_addrb), 32'd20 + 32'(k));
      checkOutput("rd_web",  32'(lut_web), 32'd0);
      @(negedge clk);
    end
    checkOutput("drain_busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("c10_busy", 32'(busy), 32'd0);
    checkOutput("c10_ready", 32'(bus.wr_ready), 32'd1);
    checkOutput("pass_verr", 32'(verify_err), 32'd0);

    // Readback with address 22 corrupted.
    corruptEn = 1'b1;
    corruptAddr = 15'd22;
    applyStimulus(28'h0ABCDEF, 13'd5, 2'd2, 1'b1);
    repeat (9) @(negedge clk);
    checkOutput("fail_verr", 32'(verify_err), 32'd1);
    checkOutput("fail_eidx", 32'(err_idx), 32'd5);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("clr_verr", 32'(verify_err), 32'd0);

    // Mismatch on the same edge as err_clr must leave the flag set.
    corruptAddr = 15'd26;
    applyStimulus(28'h0ABCDEF, 13'd6, 2'd2, 1'b1);
    err_clr = 1'b1;
    repeat (8) @(negedge clk);
    err_clr = 1'b0;
    checkOutput("clr_vs_mm_verr", 32'(verify_err), 32'd1);
    checkOutput("clr_vs_mm_eidx", 32'(err_idx), 32'd6);
    @(negedge clk);
    corruptEn = 1'b0;

    // Top index, all-ones data.
    applyStimulus(28'hFFFFFFF, 13'd8191, 2'd0, 1'b0);
    checkWrites("top", 15'd32764, 4'b0001, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    checkOutput("top_count", 32'(wr_count), 32'd5);

    // Reset in the second write cycle.
    applyStimulus(28'h0ABCDEF, 13'd7, 2'd1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_web",   32'(lut_web), 32'd0);
    checkOutput("arst_addr",  32'(lut_addrb), 32'd0);
    checkOutput("arst_din",   32'(lut_dinb), 32'd0);
    checkOutput("arst_busy",  32'(busy), 32'd0);
    checkOutput("arst_ready", 32'(bus.wr_ready), 32'd0);
    checkOutput("arst_count", 32'(wr_count), 32'd0);
    checkOutput("arst_verr",  32'(verify_err), 32'd0);
    checkOutput("arst_eidx",  32'(err_idx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_ready", 32'(bus.wr_ready), 32'd1);
    applyStimulus(28'h1234567, 13'd100, 2'd3, 1'b1);
    checkOutput("post_addr0", 32'(lut_addrb), 32'd400);
    checkOutput("post_din0",  32'(lut_dinb), 32'h67);
    checkOutput("post_web0",  32'(lut_web), 32'b1000);
    @(negedge clk);
    checkOutput("post_addr1", 32'(lut_addrb), 32'd401);
    checkOutput("post_din1",  32'(lut_dinb), 32'h0A);
    repeat (8) @(negedge clk);
    checkOutput("post_verr",  32'(verify_err), 32'd0);
    checkOutput("post_count", 32'(wr_count), 32'd1);
    checkOutput("post_ram0",  32'(ram[3][400]), 32'h67);
    checkOutput("post_ram3",  32'(ram[3][403]), 32'h09);

    // Back-to-back entries with wr_valid held.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.wr_data   = 28'h5555555;
    bus.wr_idx    = 13'd10;
    bus.wr_sel    = SEL_BPM1_Q;
    bus.verify_en = 1'b0;
    bus.wr_valid  = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
      if (bus.wr_ready) begin
        acc[n] = cyc;
        n++;
      end
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    checkOutput("tp_accepts", 32'(n), 32'd3);
    checkOutput("tp_gap1", 32'(acc[1] - acc[0]), 32'd5);
    checkOutput("tp_gap2", 32'(acc[2] - acc[1]), 32'd5);
    repeat (5) @(negedge clk);
    checkOutput("tp_count", 32'(wr_count), 32'd3);
    checkOutput("tp_ram0", 32'(ram[1][40]), 32'h55);
    checkOutput("tp_ram1", 32'(ram[1][41]), 32'h2A);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
